seq_lock_detector: RTL



---
 rtl/seq_lock_pkg.sv | 19 +
 rtl/seq_lock_fail_ctr.sv | 29 ++
 rtl/seq_lock_detector.sv | 117 +++++++++++
 3 files changed

// File: rtl/seq_lock_pkg.sv
// Shared types and helpers for the sequence lock detector.
// The state enum is 3 bits wide, so encodings 6 and 7 are unreachable.
package seq_lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_MATCH  = 3'd3,
        ST_FAIL   = 3'd4,
        ST_LOCKED = 3'd5
    } state_t;

    // Width needed to hold a failure count from 0 to max_fail.
    function automatic int cnt_width(input int max_fail);
        return $clog2(max_fail + 1);
    endfunction

endpackage

// File: rtl/seq_lock_fail_ctr.sv
// Consecutive-failure counter. It saturates at MAX_FAIL and never wraps.
// Flops update on the falling clock edge, like the rest of the detector.
module seq_lock_fail_ctr
    import seq_lock_pkg::*;
#(
    parameter int MAX_FAIL = 3,
    parameter int CW       = cnt_width(MAX_FAIL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          at_max
);

    assign at_max = (count == CW'(MAX_FAIL));

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/seq_lock_detector.sv
// Programmable-pattern sequence detector with lockout after repeated failures.
// Checks one bit MSB first, with a settle cycle between bits. Outputs decode from the registered state only.
module seq_lock_detector
    import seq_lock_pkg::*;
#(
    parameter int W        = 12,
    parameter int MAX_FAIL = 3,
    parameter int CW       = cnt_width(MAX_FAIL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  data,
    input  logic [W-1:0]  pattern,
    input  logic          unlock,
    output logic          detected,
    output logic          fail,
    output logic          locked,
    output logic          busy,
    output logic [CW-1:0] fail_cnt
);

    localparam int IW = $clog2(W);

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   snap;
    logic [W-1:0]   pat;
    logic [IW-1:0]  idx;
    logic           load;
    logic           dec;
    logic           cnt_inc;
    logic           cnt_clr;
    logic           cnt_at_max;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The counter is bumped or cleared on entry to FAIL/MATCH, so fail_cnt
    // already shows the new value while the fail or detected pulse is high.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        dec        = 1'b0;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (snap[idx] != pat[idx]) begin
                    cnt_inc    = 1'b1;
                    state_next = ST_FAIL;
                end else if (idx != '0) begin
                    state_next = ST_SETTLE;
                end else begin
                    cnt_clr    = 1'b1;
                    state_next = ST_MATCH;
                end
            end
            ST_SETTLE: begin
                dec        = 1'b1;
                state_next = ST_CHECK;
            end
            ST_MATCH: state_next = ST_IDLE;
            ST_FAIL:  state_next = cnt_at_max ? ST_LOCKED : ST_IDLE;
            ST_LOCKED: begin
                if (unlock) begin
                    cnt_clr    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap <= '0;
            pat  <= '0;
            idx  <= IW'(W - 1);
        end else if (load) begin
            snap <= data;
            pat  <= pattern;
            idx  <= IW'(W - 1);
        end else if (dec) begin
            idx <= idx - IW'(1);
        end
    end

    seq_lock_fail_ctr #(
        .MAX_FAIL (MAX_FAIL),
        .CW       (CW)
    ) u_fail_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (cnt_inc),
        .clr    (cnt_clr),
        .count  (fail_cnt),
        .at_max (cnt_at_max)
    );

    assign detected = (state == ST_MATCH);
    assign fail     = (state == ST_FAIL);
    assign locked   = (state == ST_LOCKED);
    assign busy     = (state == ST_CHECK) || (state == ST_SETTLE);

endmodule
